// File: rtl/bcd_serial_addsub_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
// Holds the FSM encoding, BCD constants and the 9's-complement helper.
package bcd_serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_NINE - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder, purely combinational (zero latency).
// No handshake; the result follows the inputs within the same cycle.
module bcd_digit_add
    import bcd_serial_addsub_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        sum  = raw[3:0];
        cout = 1'b0;
        if (raw > {1'b0, BCD_NINE}) begin
            sum  = raw[3:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// DIGITS-wide BCD add/subtract, one digit per cycle; done arrives DIGITS+1 cycles after start.
// start is ignored while busy (RUN or DONE); there is no queuing of requests.
module bcd_serial_addsub
    import bcd_serial_addsub_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);

    state_t          state, state_nxt;
    logic [W-1:0]    a_sh, b_sh, acc, b_cap;
    logic [IW-1:0]   idx;
    logic            carry, inv_lat, inv_in, digits_done;
    logic [3:0]      dsum;
    logic            dcout;

    // Validation uses the raw operands; complementing only affects the adder path.
    always_comb begin
        inv_in = 1'b0;
        b_cap  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > BCD_NINE || b[4*i +: 4] > BCD_NINE)
                inv_in = 1'b1;
            b_cap[4*i +: 4] = sub ? nines_comp(b[4*i +: 4]) : b[4*i +: 4];
        end
    end

    assign digits_done = (idx == IW'(DIGITS));

    bcd_digit_add u_digit (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)       state_nxt = ST_RUN;
            ST_RUN:  if (digits_done) state_nxt = ST_DONE;
            ST_DONE:                  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DONE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            inv_lat <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    a_sh    <= a;
                    b_sh    <= b_cap;
                    carry   <= sub | cin;
                    acc     <= '0;
                    idx     <= '0;
                    inv_lat <= inv_in;
                end
                ST_RUN: if (!digits_done) begin
                    // Digits enter at the top so digit 0 lands at the bottom after DIGITS shifts.
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    acc   <= (acc >> 4) | (W'(dsum) << (W - 4));
                    carry <= dcout;
                    idx   <= idx + 1'b1;
                end else begin
                    sum     <= inv_lat ? '0 : acc;
                    cout    <= inv_lat ? 1'b0 : carry;
                    invalid <= inv_lat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub (DIGITS=4): directed plan cases plus randomized ops
// compared against a decimal-integer reference model.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst, start, sub, cin;
    logic [15:0] a, b, sum;
    logic        cout, busy, done, invalid;
    int          passed = 0;
    int          total  = 0;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .sum(sum), .cout(cout), .busy(busy), .done(done), .invalid(invalid)
    );

    always #5 clk = ~clk;

    function automatic bit has_bad(input logic [15:0] x);
        for (int i = 0; i < 4; i++) if (x[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bcd2int(input logic [15:0] x);
        return x[15:12] * 1000 + x[11:8] * 100 + x[7:4] * 10 + x[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // Decimal reference: add gives carry beyond 9999; subtract gives sign and 10's complement.
    task automatic model(input logic [15:0] ta, tb, input logic ts, tc,
                         output logic [15:0] es, output logic ec, ei);
        int r;
        ei = has_bad(ta) || has_bad(tb);
        if (ts) r = bcd2int(ta) - bcd2int(tb);
        else    r = bcd2int(ta) + bcd2int(tb) + int'(tc);
        if (ts) begin
            ec = (r >= 0);
            es = int2bcd(r >= 0 ? r : 10000 + r);
        end else begin
            ec = (r >= 10000);
            es = int2bcd(r % 10000);
        end
        if (ei) begin es = '0; ec = 1'b0; end
    endtask

    // Starts one op, scrambles inputs after the start cycle, waits for done (bounded).
    task automatic run_op(input logic [15:0] ta, tb, input logic ts, tc,
                          output logic [15:0] rs, output logic rc, ri, output int lat);
        rs = 'x; rc = 1'bx; ri = 1'bx; lat = -1;
        @(negedge clk);
        a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                start = 1'b0; a = 16'($urandom); b = 16'($urandom);
                sub = 1'($urandom); cin = 1'($urandom);
            end
            if (done) begin lat = cyc; rs = sum; rc = cout; ri = invalid; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({sum, cout, busy, done, invalid} !== 20'd0)
            $display("FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b inv=%b want all 0",
                     sum, cout, busy, done, invalid);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [15:0] ta[6], tb[6], es[6], rs;
        logic        ts[6], tc[6], ec[6], rc, ri;
        int          lat;
        ta = '{16'h1234, 16'h9999, 16'h9999, 16'h0500, 16'h0300, 16'h0000};
        tb = '{16'h5678, 16'h0001, 16'h0001, 16'h0300, 16'h0500, 16'h0000};
        ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        es = '{16'h6912, 16'h0000, 16'h0001, 16'h0200, 16'h9800, 16'h0000};
        ec = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], ts[i], tc[i], rs, rc, ri, lat);
            total++;
            if (lat !== 5) $display("FAIL directed%0d_latency: got %0d want 5", i, lat);
            else passed++;
            total++;
            if ({rs, rc, ri} !== {es[i], ec[i], 1'b0})
                $display("FAIL directed%0d_result: got sum=%h cout=%b inv=%b want sum=%h cout=%b inv=0",
                         i, rs, rc, ri, es[i], ec[i]);
            else passed++;
        end
    endtask

    task automatic test_invalid;
        logic [15:0] rs;
        logic        rc, ri;
        int          lat;
        run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, rs, rc, ri, lat);
        total++;
        if (lat !== 5 || {rs, rc, ri} !== {16'h0000, 1'b0, 1'b1})
            $display("FAIL invalid_digit: got lat=%0d sum=%h cout=%b inv=%b want lat=5 sum=0000 cout=0 inv=1",
                     lat, rs, rc, ri);
        else passed++;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ri, lat);
        total++;
        if ({rs, rc, ri} !== {16'h0002, 1'b0, 1'b0})
            $display("FAIL invalid_recover: got sum=%h cout=%b inv=%b want sum=0002 cout=0 inv=0", rs, rc, ri);
        else passed++;
    endtask

    task automatic test_busy;
        int ndone = 0, done_cyc = -1;
        logic [15:0] rs = 'x;
        logic busy_at_done = 1'bx, busy_after = 1'bx;
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc == 0) start = 1'b0;
            if (cyc == 2) begin start = 1'b1; a = 16'h5555; b = 16'h5555; end
            if (cyc == 3) start = 1'b0;
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            if (done) begin ndone++; done_cyc = cyc; rs = sum; busy_at_done = busy; end
        end
        total++;
        if (ndone !== 1 || done_cyc !== 5)
            $display("FAIL busy_single_done: got %0d dones at cycle %0d want 1 at cycle 5", ndone, done_cyc);
        else passed++;
        total++;
        if (rs !== 16'h2222) $display("FAIL busy_sum: got %h want 2222", rs);
        else passed++;
        total++;
        if (busy_at_done !== 1'b1 || busy_after !== 1'b0)
            $display("FAIL busy_flag: got busy@done=%b busy-after=%b want 1 then 0", busy_at_done, busy_after);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] rs;
        logic        rc, ri;
        int          lat, spur = 0;
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, rs, rc, ri, lat);
        // DUT is in DONE here: a start now must be ignored.
        a = 16'h0007; b = 16'h0002; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b0) $display("FAIL done_one_cycle: got done=%b want 0", done);
        else passed++;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done || busy) spur++;
        end
        total++;
        if (spur !== 0) $display("FAIL start_in_done: got %0d busy/done cycles want 0", spur);
        else passed++;
        run_op(16'h0007, 16'h0002, 1'b0, 1'b0, rs, rc, ri, lat);
        total++;
        if (lat !== 5 || rs !== 16'h0009)
            $display("FAIL after_done_op: got lat=%0d sum=%h want lat=5 sum=0009", lat, rs);
        else passed++;
    endtask

    task automatic test_mid_reset;
        logic [15:0] rs;
        logic        rc, ri;
        int          lat, spur = 0;
        @(negedge clk);
        a = 16'h4444; b = 16'h4444; sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        total++;
        if ({sum, cout, busy, done, invalid} !== 20'd0)
            $display("FAIL midreset_outputs: got sum=%h cout=%b busy=%b done=%b inv=%b want all 0",
                     sum, cout, busy, done, invalid);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done) spur++;
        end
        total++;
        if (spur !== 0) $display("FAIL midreset_no_done: got %0d done pulses want 0", spur);
        else passed++;
        run_op(16'h0009, 16'h0009, 1'b0, 1'b0, rs, rc, ri, lat);
        total++;
        if (lat !== 5 || {rs, rc} !== {16'h0018, 1'b0})
            $display("FAIL midreset_fresh: got lat=%0d sum=%h cout=%b want lat=5 sum=0018 cout=0", lat, rs, rc);
        else passed++;
    endtask

    task automatic test_random;
        logic [15:0] ta, tb, es, rs;
        logic        ts, tc, ec, ei, rc, ri;
        int          lat;
        for (int n = 0; n < 40; n++) begin
            ta = int2bcd(int'($urandom_range(0, 9999)));
            tb = int2bcd(int'($urandom_range(0, 9999)));
            ts = 1'($urandom);
            tc = 1'($urandom);
            if ($urandom_range(0, 7) == 0) ta[4*$urandom_range(0, 3) +: 4] = 4'(10 + $urandom_range(0, 5));
            model(ta, tb, ts, tc, es, ec, ei);
            run_op(ta, tb, ts, tc, rs, rc, ri, lat);
            total++;
            if (lat !== 5 || {rs, rc, ri} !== {es, ec, ei})
                $display("FAIL random%0d: a=%h b=%h sub=%b cin=%b got lat=%0d sum=%h cout=%b inv=%b want lat=5 sum=%h cout=%b inv=%b",
                         n, ta, tb, ts, tc, lat, rs, rc, ri, es, ec, ei);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invalid();
        test_busy();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
